// File: rtl/dip_sort_pkg.sv
// Shared types, defaults and lane helpers for the dip_median rank-order sorter.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package dip_sort_pkg;

  localparam int DEF_DAT_WDTH = 8;
  localparam int DEF_NUM_VAL  = 5;

  // Default-width lane type, for blocks that run at the default sample width.
  typedef logic [DEF_DAT_WDTH-1:0] dflt_lane_t;

  // Sorted lane that holds the median of an odd-sized window.
  function automatic int med_idx(input int num_val);
    return num_val / 2;
  endfunction

  localparam int DEF_MED_IDX = med_idx(DEF_NUM_VAL);

  // LSB position of a lane inside a flat packed lane vector.
  function automatic int lane_lsb(input int lane, input int dat_wdth);
    return lane * dat_wdth;
  endfunction

  // True when lane is the low member of a compare pair in the given pass
  // of the odd-even transposition network.
  function automatic bit pair_lo(input int lane, input int pass, input int num_val);
    return ((lane % 2) == (pass % 2)) && (lane < (num_val - 1)) && (lane >= 0);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single unsigned compare-exchange: lo_o gets the smaller, hi_o the larger.
// Latency: combinational.
// Backpressure: none; swaps only on strict a_i > b_i so equal values keep their lanes.
module sort_cmp_swap
  import dip_sort_pkg::*;
#(
  parameter int DAT_WDTH = DEF_DAT_WDTH
) (
  input  logic [DAT_WDTH-1:0] a_i,
  input  logic [DAT_WDTH-1:0] b_i,
  output logic [DAT_WDTH-1:0] lo_o,
  output logic [DAT_WDTH-1:0] hi_o
);

  logic swap;

  assign swap = (a_i > b_i);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_n_pipe.sv
// Pipelined odd-even transposition sorter returning min, median, max and a selectable k-th value.
// Latency: NUM_VAL register stages; accepted at edge T, out_valid after edge T+NUM_VAL-1.
// Backpressure: global stall; out_valid & ~out_ready freezes every stage and drops in_ready the same cycle.
module sort_n_pipe
  import dip_sort_pkg::*;
#(
  parameter  int DAT_WDTH = DEF_DAT_WDTH,
  parameter  int NUM_VAL  = DEF_NUM_VAL,
  localparam int RNK_WDTH = $clog2(NUM_VAL)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_VAL*DAT_WDTH-1:0]  in_data,
  input  logic [RNK_WDTH-1:0]          in_rank,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DAT_WDTH-1:0]          out_min,
  output logic [DAT_WDTH-1:0]          out_med,
  output logic [DAT_WDTH-1:0]          out_max,
  output logic [DAT_WDTH-1:0]          out_rank_val
);

  // Lane stages ahead of the output register; the last pass feeds the output stage directly.
  localparam int                NUM_STG = NUM_VAL - 1;
  localparam int                MED_IDX = med_idx(NUM_VAL);
  localparam logic [RNK_WDTH-1:0] RNK_MAX = RNK_WDTH'(NUM_VAL - 1);

  if ((NUM_VAL < 3) || ((NUM_VAL % 2) == 0)) begin : g_bad_num_val
    $error("sort_n_pipe: NUM_VAL must be odd and >= 3");
  end

  typedef logic [NUM_VAL-1:0][DAT_WDTH-1:0] lanes_t;

  logic                clr;
  logic                advance;
  lanes_t              in_lanes;
  logic [RNK_WDTH-1:0] rank_d;

  lanes_t              pass_in  [NUM_VAL];
  lanes_t              pass_out [NUM_VAL];

  lanes_t              lanes_q [NUM_STG];
  logic [RNK_WDTH-1:0] rank_q  [NUM_STG];
  logic [NUM_STG-1:0]  vld_q;

  logic                out_valid_q;
  logic [DAT_WDTH-1:0] out_min_q;
  logic [DAT_WDTH-1:0] out_med_q;
  logic [DAT_WDTH-1:0] out_max_q;
  logic [DAT_WDTH-1:0] out_rank_val_q;

  // Either reset source clears the whole pipe; no handshake is taken while it is asserted.
  assign clr      = ~rst_n | ~sw_rst_n;
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance & ~clr;

  // Unpack the flat input bus into lanes and clamp out-of-range ranks to the max lane.
  always_comb begin
    in_lanes = '0;
    for (int i = 0; i < NUM_VAL; i++) begin
      in_lanes[i] = in_data[lane_lsb(i, DAT_WDTH) +: DAT_WDTH];
    end
    rank_d = (in_rank > RNK_MAX) ? RNK_MAX : in_rank;
  end

  // One compare-exchange column per pass; lanes without a partner pass straight through.
  for (genvar s = 0; s < NUM_VAL; s++) begin : g_pass
    if (s == 0) begin : g_src_in
      assign pass_in[s] = in_lanes;
    end else begin : g_src_stg
      assign pass_in[s] = lanes_q[s-1];
    end

    for (genvar i = 0; i < NUM_VAL; i++) begin : g_lane
      if (pair_lo(i, s, NUM_VAL)) begin : g_cmp
        sort_cmp_swap #(
          .DAT_WDTH (DAT_WDTH)
        ) u_cmp (
          .a_i  (pass_in[s][i]),
          .b_i  (pass_in[s][i+1]),
          .lo_o (pass_out[s][i]),
          .hi_o (pass_out[s][i+1])
        );
      end else if (!pair_lo(i - 1, s, NUM_VAL)) begin : g_thru
        assign pass_out[s][i] = pass_in[s][i];
      end
    end
  end

  // Lane stage registers: data, rank and valid move together, only when the pipe advances.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
      for (int s = 0; s < NUM_STG; s++) begin
        lanes_q[s] <= '0;
        rank_q[s]  <= '0;
      end
    end else if (advance) begin
      vld_q[0]   <= in_valid;
      lanes_q[0] <= pass_out[0];
      rank_q[0]  <= rank_d;
      for (int s = 1; s < NUM_STG; s++) begin
        vld_q[s]   <= vld_q[s-1];
        lanes_q[s] <= pass_out[s];
        rank_q[s]  <= rank_q[s-1];
      end
    end
  end

  // Output stage: registers the final pass; data only updates on a real result so bubbles leave it alone.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid_q    <= 1'b0;
      out_min_q      <= '0;
      out_med_q      <= '0;
      out_max_q      <= '0;
      out_rank_val_q <= '0;
    end else if (advance) begin
      out_valid_q <= vld_q[NUM_STG-1];
      if (vld_q[NUM_STG-1]) begin
        out_min_q      <= pass_out[NUM_VAL-1][0];
        out_med_q      <= pass_out[NUM_VAL-1][MED_IDX];
        out_max_q      <= pass_out[NUM_VAL-1][NUM_VAL-1];
        out_rank_val_q <= pass_out[NUM_VAL-1][rank_q[NUM_STG-1]];
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_min      = out_min_q;
  assign out_med      = out_med_q;
  assign out_max      = out_max_q;
  assign out_rank_val = out_rank_val_q;

endmodule

// File: tb/tb_sort_n_pipe.sv
// Self-checking bench for sort_n_pipe against a queue-sort reference model.
// Latency: checks NUM_VAL-1 edges from acceptance to out_valid.
// Backpressure: exercises stalls, software clear and random out_ready.
module tb_sort_n_pipe;

  localparam int W     = 8;
  localparam int N     = 5;
  localparam int RW    = $clog2(N);
  localparam int NRAND = 3000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sw_rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic [RW-1:0]   in_rank;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_min;
  logic [W-1:0]    out_med;
  logic [W-1:0]    out_max;
  logic [W-1:0]    out_rank_val;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mn;
    int md;
    int mx;
    int rv;
  } res_t;

  res_t exp_q[$];

  // Directed vectors with hand-derived results {min, med, max, rank_val}.
  int vec  [4][N] = '{'{9, 3, 7, 1, 5}, '{4, 4, 2, 2, 4}, '{255, 255, 255, 255, 255}, '{0, 200, 100, 50, 25}};
  int rk   [4]    = '{1, 4, 2, 7};
  int dexp [4][4] = '{'{1, 5, 9, 3}, '{2, 4, 4, 4}, '{255, 255, 255, 255}, '{0, 50, 200, 200}};

  always #5 clk = ~clk;

  sort_n_pipe #(
    .DAT_WDTH (W),
    .NUM_VAL  (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_n     (sw_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_rank      (in_rank),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_min      (out_min),
    .out_med      (out_med),
    .out_max      (out_max),
    .out_rank_val (out_rank_val)
  );

  function automatic logic [N*W-1:0] pack_lanes(input int v[N]);
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(v[i]);
    return d;
  endfunction

  function automatic logic [N*W-1:0] rand_lanes();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) begin
      // Narrow range half the time so duplicates show up often.
      if ($urandom_range(0, 1) == 0) d[i*W +: W] = W'($urandom_range(0, 3));
      else d[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    end
    return d;
  endfunction

  // Reference: sort the window, then read off the requested order statistics.
  function automatic res_t ref_model(input logic [N*W-1:0] d, input int rank);
    int   q[$];
    res_t r;
    for (int i = 0; i < N; i++) q.push_back(int'(d[i*W +: W]));
    q.sort();
    r.mn = q[0];
    r.md = q[N/2];
    r.mx = q[N-1];
    r.rv = q[(rank >= N) ? N-1 : rank];
    return r;
  endfunction

  function automatic logic [4*W-1:0] res_bits(input res_t r);
    return {W'(r.mn), W'(r.md), W'(r.mx), W'(r.rv)};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    sw_rst_n  = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    in_rank   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready);
    end
    total++;
    if ({out_valid, out_min, out_med, out_max, out_rank_val} !== '0) begin
      bad++; $display("FAIL reset_outputs: got v=%0b %0d %0d %0d %0d want all 0", out_valid, out_min, out_med, out_max, out_rank_val);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset: got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 4; k++) begin
      int             lat;
      logic [4*W-1:0] ev;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = pack_lanes(vec[k]);
      in_rank   = RW'(rk[k]);
      out_ready = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL directed_in_ready[%0d]: got %0b want 1", k, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat != N - 1) begin
        bad++; $display("FAIL directed_latency[%0d]: got %0d edges want %0d", k, lat, N - 1);
      end
      ev = {W'(dexp[k][0]), W'(dexp[k][1]), W'(dexp[k][2]), W'(dexp[k][3])};
      total++;
      if ({out_min, out_med, out_max, out_rank_val} !== ev) begin
        bad++; $display("FAIL directed_value[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", k,
                        out_min, out_med, out_max, out_rank_val, dexp[k][0], dexp[k][1], dexp[k][2], dexp[k][3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int             sent = 0;
    int             got  = 0;
    bit             stalled_prev = 1'b0;
    logic [4*W-1:0] prev_out = '0;
    res_t           e;
    exp_q.delete();
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      in_data   = rand_lanes();
      in_rank   = RW'($urandom_range(0, (1 << RW) - 1));
      out_ready = !(c >= 7 && c < 10);
      @(negedge clk);
      if (stalled_prev) begin
        total++;
        if (out_valid !== 1'b1 || {out_min, out_med, out_max, out_rank_val} !== prev_out) begin
          bad++; $display("FAIL b2b_hold[c%0d]: got v=%0b %h want v=1 %h", c, out_valid, {out_min, out_med, out_max, out_rank_val}, prev_out);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_stall_in_ready[c%0d]: got %0b want 0", c, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data, int'(in_rank)));
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra[c%0d]: got unexpected result want none", c);
        end else begin
          e = exp_q.pop_front();
          if ({out_min, out_med, out_max, out_rank_val} !== res_bits(e)) begin
            bad++; $display("FAIL b2b_value[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", got,
                            out_min, out_med, out_max, out_rank_val, e.mn, e.md, e.mx, e.rv);
          end
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_out     = {out_min, out_med, out_max, out_rank_val};
    end
    total++;
    if (got != 8 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count: got %0d results (%0d pending) want 8 (0)", got, exp_q.size());
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_sw_reset();
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = rand_lanes();
      in_rank  = RW'($urandom_range(0, N - 1));
    end
    @(posedge clk); #1;
    sw_rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL swrst_in_ready: got %0b want 0", in_ready);
    end
    @(posedge clk); #1;
    sw_rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_min, out_med, out_max, out_rank_val} !== '0) begin
      bad++; $display("FAIL swrst_outputs: got v=%0b %0d %0d %0d %0d want all 0", out_valid, out_min, out_med, out_max, out_rank_val);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL swrst_flushed: got %0d valid cycles want 0", seen);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = pack_lanes(vec[0]);
    in_rank  = RW'(rk[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != N - 1 || {out_min, out_med, out_max, out_rank_val} !== {W'(1), W'(5), W'(9), W'(3)}) begin
      bad++; $display("FAIL swrst_after: got lat=%0d %0d %0d %0d %0d want lat=%0d 1 5 9 3", lat,
                      out_min, out_med, out_max, out_rank_val, N - 1);
    end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    res_t e;
    exp_q.delete();
    while ((sent < NRAND || got < sent) && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      if (sent < NRAND) begin
        in_valid = ($urandom_range(0, 9) < 8);
        in_data  = rand_lanes();
        in_rank  = RW'($urandom_range(0, (1 << RW) - 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data, int'(in_rank)));
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra[cyc%0d]: got unexpected result want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({out_min, out_med, out_max, out_rank_val} !== res_bits(e)) begin
            bad++; $display("FAIL rand_value[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", got,
                            out_min, out_med, out_max, out_rank_val, e.mn, e.md, e.mx, e.rv);
          end
        end
        got++;
      end
    end
    total++;
    if (got != NRAND || exp_q.size() != 0) begin
      bad++; $display("FAIL rand_count: got %0d results (%0d pending) want %0d (0)", got, exp_q.size(), NRAND);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_sw_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
